wb_arbiter: RTL and testbench

- Write-back stage directly upstream of the register file write port (we3/wa3/wd3).
- Merges two result producers into the single write port:
  - single-cycle ALU results, which are never stalled;
  - variable-latency load results, accepted via valid/ready and buffered in a small FIFO.
- Enforces write-after-write ordering between them.
- Exports a pending-register mask so issue logic can detect loads still in flight.

---
 rtl/wb_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_wb_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back stage feeding the register file write port.
// Merges never-stalled ALU results with load results buffered in a small
// FIFO, keeps write-after-write order (ALU results are always younger than
// buffered loads) and exports a mask of registers with live loads in flight.
module wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alu_valid,
  input  logic [ADDR_W-1:0]         alu_rd,
  input  logic [DATA_W-1:0]         alu_data,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic [ADDR_W-1:0]         mem_rd,
  input  logic [DATA_W-1:0]         mem_data,
  output logic                      we3,
  output logic [ADDR_W-1:0]         wa3,
  output logic [DATA_W-1:0]         wd3,
  output logic [(2**ADDR_W)-1:0]    pending,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 2**ADDR_W;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] ZERO_RD = {ADDR_W{1'b0}};

  // FIFO storage
  logic [ADDR_W-1:0] rd_r   [DEPTH];
  logic [DATA_W-1:0] data_r [DEPTH];
  logic [DEPTH-1:0]  live_r;
  logic [PTR_W-1:0]  wptr_r;
  logic [PTR_W-1:0]  rptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              ready_r;

  // Output registers
  logic              we3_r;
  logic [ADDR_W-1:0] wa3_r;
  logic [DATA_W-1:0] wd3_r;
  logic [NREG-1:0]   pending_r;

  // Next-state signals
  logic              push_s;
  logic              pop_s;
  logic              kill_s;
  logic [ADDR_W-1:0] rd_nxt_s   [DEPTH];
  logic [DATA_W-1:0] data_nxt_s [DEPTH];
  logic [DEPTH-1:0]  live_nxt_s;
  logic [NREG-1:0]   pending_nxt_s;
  logic [CNT_W-1:0]  count_nxt_s;
  logic              we_nxt_s;
  logic [ADDR_W-1:0] wa_nxt_s;
  logic [DATA_W-1:0] wd_nxt_s;

  // mem_ready comes straight from a register, so no input reaches it combinationally.
  assign push_s = mem_valid && ready_r;
  // The ALU owns the write port whenever it is valid; the FIFO only drains in idle ALU cycles.
  assign pop_s  = !alu_valid && (count_r != {CNT_W{1'b0}});
  assign kill_s = alu_valid && (alu_rd != ZERO_RD);

  assign mem_ready = ready_r;
  assign we3       = we3_r;
  assign wa3       = wa3_r;
  assign wd3       = wd3_r;
  assign pending   = pending_r;
  assign count     = count_r;

  // Slot contents after this edge: the tail slot takes the offered load on a push.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push_s && (wptr_r == PTR_W'(i))) begin
        rd_nxt_s[i]   = mem_rd;
        data_nxt_s[i] = mem_data;
      end else begin
        rd_nxt_s[i]   = rd_r[i];
        data_nxt_s[i] = data_r[i];
      end
    end
  end

  // Live bits after this edge: WAW kill, then pop invalidation, then push (killed if it collides with the ALU).
  always_comb begin
    live_nxt_s = live_r;
    for (int i = 0; i < DEPTH; i++) begin
      if (kill_s && (rd_r[i] == alu_rd)) begin
        live_nxt_s[i] = 1'b0;
      end else begin
        live_nxt_s[i] = live_nxt_s[i];
      end
    end
    if (pop_s) begin
      live_nxt_s[rptr_r] = 1'b0;
    end else begin
      live_nxt_s[rptr_r] = live_nxt_s[rptr_r];
    end
    if (push_s) begin
      live_nxt_s[wptr_r] = !(kill_s && (mem_rd == alu_rd));
    end else begin
      live_nxt_s[wptr_r] = live_nxt_s[wptr_r];
    end
  end

  // Pending mask built from the post-edge live entries; register 0 is never pending.
  always_comb begin
    pending_nxt_s = {NREG{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (live_nxt_s[i]) begin
        pending_nxt_s[rd_nxt_s[i]] = 1'b1;
      end else begin
        pending_nxt_s = pending_nxt_s;
      end
    end
    pending_nxt_s[0] = 1'b0;
  end

  // Occupancy counts killed entries too; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Write-port selection: ALU first, then FIFO head; otherwise address/data hold.
  always_comb begin
    we_nxt_s = 1'b0;
    wa_nxt_s = wa3_r;
    wd_nxt_s = wd3_r;
    if (alu_valid) begin
      we_nxt_s = (alu_rd != ZERO_RD);
      wa_nxt_s = alu_rd;
      wd_nxt_s = alu_data;
    end else if (pop_s) begin
      we_nxt_s = live_r[rptr_r] && (rd_r[rptr_r] != ZERO_RD);
      wa_nxt_s = rd_r[rptr_r];
      wd_nxt_s = data_r[rptr_r];
    end else begin
      we_nxt_s = 1'b0;
    end
  end

  // State and output registers; reset drops every buffered load without writing it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_r[i]   <= ZERO_RD;
        data_r[i] <= {DATA_W{1'b0}};
      end
      live_r    <= {DEPTH{1'b0}};
      wptr_r    <= {PTR_W{1'b0}};
      rptr_r    <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      ready_r   <= 1'b0;
      we3_r     <= 1'b0;
      wa3_r     <= ZERO_RD;
      wd3_r     <= {DATA_W{1'b0}};
      pending_r <= {NREG{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_r[i]   <= rd_nxt_s[i];
        data_r[i] <= data_nxt_s[i];
      end
      live_r    <= live_nxt_s;
      wptr_r    <= push_s ? (wptr_r + PTR_W'(1)) : wptr_r;
      rptr_r    <= pop_s ? (rptr_r + PTR_W'(1)) : rptr_r;
      count_r   <= count_nxt_s;
      ready_r   <= (count_nxt_s < DEPTH_C);
      we3_r     <= we_nxt_s;
      wa3_r     <= wa_nxt_s;
      wd3_r     <= wd_nxt_s;
      pending_r <= pending_nxt_s;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scoreboard bench for wb_arbiter. A reference FIFO model
// predicts each cycle's register-file write; the prediction is queued when
// stimulus is driven and popped/compared after the clock edge.
module tb_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
  localparam int NREG   = 2**ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              we3;
  logic [ADDR_W-1:0] wa3;
  logic [DATA_W-1:0] wd3;
  logic [NREG-1:0]   pending;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .we3(we3), .wa3(wa3), .wd3(wd3), .pending(pending), .count(count)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
    logic              live;
  } ent_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
  } wr_t;

  ent_t mq[$];
  wr_t  exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic              m_rst_done;
  logic [ADDR_W-1:0] m_wa;
  logic [DATA_W-1:0] m_wd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NREG-1:0] model_pending();
    logic [NREG-1:0] p;
    p = '0;
    foreach (mq[i]) begin
      if (mq[i].live && (mq[i].rd != 5'd0)) p[mq[i].rd] = 1'b1;
    end
    return p;
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_rst_done = 1'b0;
    m_wa = '0;
    m_wd = '0;
  endtask

  // One clock cycle: drive at posedge+1, predict, then compare at the next posedge+1.
  task automatic step(input logic av, input logic [ADDR_W-1:0] ard, input logic [DATA_W-1:0] ad,
                      input logic mv, input logic [ADDR_W-1:0] mrd, input logic [DATA_W-1:0] md);
    wr_t  w;
    ent_t e;
    logic m_ready;
    logic kill;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    m_ready = m_rst_done && (mq.size() < DEPTH);
    #1;
    check("mem_ready", {63'd0, mem_ready}, {63'd0, m_ready});
    kill = av && (ard != 5'd0);
    w.we = 1'b0; w.wa = m_wa; w.wd = m_wd;
    if (av) begin
      w.we = kill; w.wa = ard; w.wd = ad;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      w.we = e.live && (e.rd != 5'd0); w.wa = e.rd; w.wd = e.data;
    end
    if (kill) begin
      foreach (mq[i]) begin
        if (mq[i].rd == ard) begin
          e = mq[i]; e.live = 1'b0; mq[i] = e;
        end
      end
    end
    if (mv && m_ready) begin
      e.rd = mrd; e.data = md; e.live = !(kill && (mrd == ard));
      mq.push_back(e);
    end
    m_wa = w.wa; m_wd = w.wd;
    exp_q.push_back(w);
    @(posedge clk); #1;
    m_rst_done = 1'b1;
    w = exp_q.pop_front();
    check("we3", {63'd0, we3}, {63'd0, w.we});
    check("wa3", {59'd0, wa3}, {59'd0, w.wa});
    check("wd3", {32'd0, wd3}, {32'd0, w.wd});
    check("count", {60'd0, count}, 64'(mq.size()));
    check("pending", {32'd0, pending}, {32'd0, model_pending()});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_we3", {63'd0, we3}, 64'd0);
    check("rst_pending", {32'd0, pending}, 64'd0);
    check("rst_count", {60'd0, count}, 64'd0);
    check("rst_mem_ready", {63'd0, mem_ready}, 64'd0);
    rst_n = 1'b1;

    // Single ALU write, then quiet.
    step(1'b1, 5'd18, 32'd255, 1'b0, 5'd0, 32'd0);
    idle(2);

    // Fill the FIFO while the ALU holds the port, one rejected offer, then drain 1..4.
    for (int i = 1; i <= 4; i++)
      step(1'b1, 5'd20, 32'(i), 1'b1, 5'(i), 32'(i * 17));
    check("fill_pending", {32'd0, pending}, 64'h1E);
    step(1'b1, 5'd20, 32'd99, 1'b1, 5'd5, 32'h55);
    idle(6);

    // WAW kill: load to 19 then ALU to 19.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd19, 32'd170);
    step(1'b1, 5'd19, 32'd85, 1'b0, 5'd0, 32'd0);
    check("waw_pending19", {63'd0, pending[19]}, 64'd0);
    idle(3);

    // Same-cycle collision on register 7.
    step(1'b1, 5'd7, 32'hA7, 1'b1, 5'd7, 32'h77);
    idle(3);

    // Register 0 from both producers.
    step(1'b1, 5'd0, 32'h99, 1'b1, 5'd0, 32'h55);
    idle(3);

    // Build count=3, then asynchronous reset between edges.
    for (int i = 0; i < 3; i++)
      step(1'b1, 5'd9, 32'(100 + i), 1'b1, 5'(8 + 2 * i), 32'(200 + i));
    check("pre_rst_count", {60'd0, count}, 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_we3", {63'd0, we3}, 64'd0);
    check("arst_pending", {32'd0, pending}, 64'd0);
    check("arst_count", {60'd0, count}, 64'd0);
    check("arst_mem_ready", {63'd0, mem_ready}, 64'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(4);

    // Random mixed traffic over a small register range to provoke collisions.
    for (int k = 0; k < 300; k++)
      step(($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom);
    idle(DEPTH + 2);
    check("drain_count", {60'd0, count}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
